// File: rtl/ca_cfar_detector_pkg.sv
// Shared types and derived constants for the cell-averaging CFAR detector.
// Sizing helpers let the top and the window derive widths from REF/GUARD.
package ca_cfar_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } cfar_state_e;

  // Fraction bits of the Q12.4 threshold factor
  localparam int FRAC_W = 4;

  localparam int REF_DEF   = 8;
  localparam int GUARD_DEF = 1;

  function automatic int cfar_win_len(input int r, input int g);
    return 2 * r + 2 * g + 1;
  endfunction

  function automatic int cfar_latency(input int r, input int g);
    return r + g + 2;
  endfunction

  function automatic int cfar_log2_2r(input int r);
    return $clog2(2 * r);
  endfunction

  localparam int CFAR_W       = cfar_win_len(REF_DEF, GUARD_DEF);
  localparam int CFAR_L       = cfar_latency(REF_DEF, GUARD_DEF);
  localparam int CFAR_LOG2_2R = cfar_log2_2r(REF_DEF);

endpackage

// File: rtl/cfar_window.sv
// Sliding window of magnitude samples with running leading/lagging reference sums.
// Index 0 holds the newest sample; the CUT sits in the middle of the window.
module cfar_window
  import ca_cfar_detector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REF    = REF_DEF,
  parameter int GUARD  = GUARD_DEF
) (
  input  logic                                Clk_40,
  input  logic                                Rst,
  input  logic                                clear,
  input  logic                                shift,
  input  logic                                run,
  input  logic [DATA_W-1:0]                   din,
  output logic [DATA_W-1:0]                   cut,
  output logic [DATA_W+cfar_log2_2r(REF)-1:0] ref_sum,
  output logic                                cut_valid
);

  localparam int WIN   = cfar_win_len(REF, GUARD);
  localparam int SUM_W = DATA_W + cfar_log2_2r(REF) - 1;
  localparam int CUT_I = REF + GUARD;
  localparam int LAG_I = REF + 2 * GUARD;

  logic [DATA_W-1:0] win [WIN];
  logic [SUM_W-1:0]  s_lead;
  logic [SUM_W-1:0]  s_lag;
  logic [SUM_W-1:0]  lead_nxt;
  logic [SUM_W-1:0]  lag_nxt;

  // Incremental update: the cell entering each region is added, the leaving one removed
  always_comb begin
    lead_nxt = s_lead + SUM_W'(din) - SUM_W'(win[REF-1]);
    lag_nxt  = s_lag + SUM_W'(win[LAG_I]) - SUM_W'(win[WIN-1]);
  end

  always_ff @(posedge Clk_40 or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      s_lead    <= '0;
      s_lag     <= '0;
      cut_valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      s_lead    <= '0;
      s_lag     <= '0;
      cut_valid <= 1'b0;
    end else begin
      cut_valid <= shift & run;
      if (shift) begin
        win[0] <= din;
        for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
        s_lead <= lead_nxt;
        s_lag  <= lag_nxt;
      end
    end
  end

  assign cut     = win[CUT_I];
  assign ref_sum = {1'b0, s_lead} + {1'b0, s_lag};

endmodule

// File: rtl/ca_cfar_detector.sv
// CA-CFAR detector: sweep FSM, registered threshold compare, detection counter
// and PRF strobe realignment around the cfar_window shift register.
module ca_cfar_detector
  import ca_cfar_detector_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REF       = REF_DEF,
  parameter int GUARD     = GUARD_DEF,
  parameter int GATE_W    = 10,
  parameter int NUM_GATES = 800
) (
  input  logic              Clk_40,
  input  logic              Rst,
  input  logic              Prf_in,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [15:0]       T,
  output logic              Target_flag,
  output logic [GATE_W-1:0] Target_gate,
  output logic              Prf_out,
  output logic [GATE_W-1:0] Det_count,
  output cfar_state_e       dbg_state
);

  localparam int LOG2_2R   = cfar_log2_2r(REF);
  localparam int L         = cfar_latency(REF, GUARD);
  localparam int SUM_W1    = DATA_W + LOG2_2R;
  localparam int PROD_W    = 16 + SUM_W1;
  localparam int SHIFT     = LOG2_2R + FRAC_W;
  localparam int FILL_LAST = 2 * (REF + GUARD) - 1;
  localparam int LAST_GATE = NUM_GATES - 1;

  cfar_state_e       state;
  logic [GATE_W-1:0] gate;
  logic [15:0]       t_q;
  logic [GATE_W-1:0] det_cnt;

  // Data_in is a valid-only stream with no backpressure: in FILL/RUN every
  // cycle without Prf_in carries exactly one accepted gate sample.
  logic              acc_v;
  logic              acc_run;
  logic [DATA_W-1:0] acc_d;
  logic [GATE_W-1:0] acc_gate;
  logic [GATE_W-1:0] cut_gate;

  logic [DATA_W-1:0] cut;
  logic [SUM_W1-1:0] ref_sum;
  logic              cut_valid;
  logic [PROD_W-1:0] lhs;
  logic [PROD_W-1:0] rhs;
  logic              hit;
  logic [L-1:0]      prf_sr;

  cfar_window #(
    .DATA_W (DATA_W),
    .REF    (REF),
    .GUARD  (GUARD)
  ) u_window (
    .Clk_40    (Clk_40),
    .Rst       (Rst),
    .clear     (Prf_in),
    .shift     (acc_v),
    .run       (acc_run),
    .din       (acc_d),
    .cut       (cut),
    .ref_sum   (ref_sum),
    .cut_valid (cut_valid)
  );

  // Full-width compare: CUT scaled by 2*REF and the Q12.4 fraction vs T * sum
  always_comb begin
    lhs = PROD_W'(cut) << SHIFT;
    rhs = PROD_W'(t_q) * PROD_W'(ref_sum);
    hit = cut_valid && (lhs > rhs);
  end

  always_ff @(posedge Clk_40 or posedge Rst) begin
    if (Rst) begin
      state       <= ST_IDLE;
      gate        <= '0;
      t_q         <= '0;
      det_cnt     <= '0;
      Det_count   <= '0;
      acc_v       <= 1'b0;
      acc_run     <= 1'b0;
      acc_d       <= '0;
      acc_gate    <= '0;
      cut_gate    <= '0;
      Target_flag <= 1'b0;
      Target_gate <= '0;
    end else begin
      acc_v       <= 1'b0;
      Target_flag <= 1'b0;
      if (Prf_in) begin
        // Restart: in-flight flags die here because acc_v/cut_valid/flag all clear
        state     <= ST_FILL;
        gate      <= '0;
        t_q       <= T;
        Det_count <= det_cnt;
        det_cnt   <= '0;
      end else begin
        if (hit) begin
          Target_flag <= 1'b1;
          Target_gate <= cut_gate;
          if (det_cnt != {GATE_W{1'b1}}) det_cnt <= det_cnt + 1'b1;
        end
        if (acc_v) cut_gate <= acc_gate - GATE_W'(REF + GUARD);
        unique case (state)
          ST_FILL: begin
            acc_v    <= 1'b1;
            acc_run  <= 1'b0;
            acc_d    <= Data_in;
            acc_gate <= gate;
            gate     <= gate + 1'b1;
            if (gate == GATE_W'(FILL_LAST)) state <= ST_RUN;
          end
          ST_RUN: begin
            acc_v    <= 1'b1;
            acc_run  <= 1'b1;
            acc_d    <= Data_in;
            acc_gate <= gate;
            if (gate == GATE_W'(LAST_GATE)) state <= ST_DONE;
            else gate <= gate + 1'b1;
          end
          ST_DONE: begin
            Det_count <= det_cnt;
            state     <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk_40 or posedge Rst) begin
    if (Rst) begin
      prf_sr  <= '0;
      Prf_out <= 1'b0;
    end else begin
      prf_sr  <= {prf_sr[L-2:0], Prf_in};
      Prf_out <= prf_sr[L-1];
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ca_cfar_detector.sv
// Self-checking bench for ca_cfar_detector: table-driven sweeps plus restart,
// back-to-back and async-reset sequences, with a flag/PRF scoreboard.
module tb_ca_cfar_detector;
  import ca_cfar_detector_pkg::*;

  localparam int NG    = 800;
  localparam int HALF  = (CFAR_W - 1) / 2;
  localparam int GRD   = 1;
  localparam int NREF  = HALF - GRD;
  localparam int EW    = 42;
  localparam int NTBL  = 9;

  logic        Clk_40;
  logic        Rst;
  logic        Prf_in;
  logic [31:0] Data_in;
  logic [15:0] T;
  logic        Target_flag;
  logic [9:0]  Target_gate;
  logic        Prf_out;
  logic [9:0]  Det_count;
  cfar_state_e dbg_state;

  ca_cfar_detector dut (
    .Clk_40      (Clk_40),
    .Rst         (Rst),
    .Prf_in      (Prf_in),
    .Data_in     (Data_in),
    .T           (T),
    .Target_flag (Target_flag),
    .Target_gate (Target_gate),
    .Prf_out     (Prf_out),
    .Det_count   (Det_count),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter: after rising edge n, cyc == n
  int cyc = 0;
  initial Clk_40 = 1'b0;
  always #5 Clk_40 = ~Clk_40;
  always @(posedge Clk_40) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int prev_cnt = 0;
  logic [EW-1:0] exp_q[$];
  int prf_q[$];
  logic [31:0] data [NG];

  typedef struct {
    logic [15:0] t;
    int          gate;
    logic [31:0] val;
    bit          flag;
  } vec_t;
  vec_t tbl [NTBL];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_flag(input int p, input int g);
    logic [31:0] e;
    logic [9:0]  gg;
    e  = 32'(p + 1 + g + CFAR_L);
    gg = 10'(g);
    exp_q.push_back({e, gg});
  endfunction

  // Direct (non-incremental) reference: flags only if emitted before the sweep ends/restarts
  function automatic int push_model(input int p, input int n, input logic [15:0] t);
    int cnt = 0;
    for (int g = HALF; g <= NG - 1 - HALF; g++) begin
      longint lead = 0;
      longint lag = 0;
      longint lhs;
      if (g + CFAR_L >= n) continue;
      for (int j = GRD + 1; j <= GRD + NREF; j++) begin
        lead += longint'(data[g + j]);
        lag  += longint'(data[g - j]);
      end
      lhs = longint'(data[g]) << (CFAR_LOG2_2R + 4);
      if (lhs > longint'(t) * (lead + lag)) begin
        push_flag(p, g);
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic fill_bg(input int lo, input int hi);
    for (int i = 0; i < NG; i++) data[i] = 32'($urandom_range(hi, lo));
  endtask

  // driver: Prf_in, then n gates; a following call restarts right at gate n
  task automatic drive_sweep(input int n, input logic [15:0] t_val, input bit use_model,
                             input int tbl_gate);
    int p;
    int cnt;
    @(posedge Clk_40); #1;
    Prf_in  = 1'b1;
    T       = t_val;
    Data_in = $urandom;
    p = cyc + 1;
    prf_q.push_back(p + CFAR_L);
    cnt = 0;
    if (use_model) cnt = push_model(p, n, t_val);
    else if (tbl_gate >= 0) begin
      push_flag(p, tbl_gate);
      cnt = 1;
    end
    for (int k = 0; k < n; k++) begin
      @(posedge Clk_40); #1;
      Prf_in  = 1'b0;
      T       = 16'($urandom);
      Data_in = data[k];
      if (k == 5) check("det_count_prev_sweep", Det_count, prev_cnt);
    end
    prev_cnt = cnt;
  endtask

  // scoreboard monitors, sampled on the falling edge
  always @(negedge Clk_40) begin
    if (Target_flag) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_flag: got gate %0d at cycle %0d, expected no flag", Target_gate, cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("flag_cycle", cyc, e[EW-1:10]);
        check("flag_gate", Target_gate, e[9:0]);
      end
    end
    if (Prf_out) begin
      if (prf_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_prf_out: got 1 at cycle %0d, expected 0", cyc);
      end else begin
        check("prf_out_cycle", cyc, prf_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0] = '{16'd32, 100, 32'd250, 1'b1};
    tbl[1] = '{16'd32, 300, 32'd200, 1'b0};
    tbl[2] = '{16'd32, 300, 32'd199, 1'b0};
    tbl[3] = '{16'd32, 300, 32'd201, 1'b1};
    tbl[4] = '{16'd32,   5, 32'd1000, 1'b0};
    tbl[5] = '{16'd32, 795, 32'd1000, 1'b0};
    tbl[6] = '{16'd32,   9, 32'd250, 1'b1};
    tbl[7] = '{16'd48, 400, 32'd300, 1'b0};
    tbl[8] = '{16'd48, 400, 32'd301, 1'b1};

    Rst = 1'b1; Prf_in = 1'b0; Data_in = '0; T = '0;
    repeat (3) @(posedge Clk_40);
    #1;
    check("rst_target_flag", Target_flag, 0);
    check("rst_target_gate", Target_gate, 0);
    check("rst_prf_out", Prf_out, 0);
    check("rst_det_count", Det_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    Rst = 1'b0;
    repeat (2) @(posedge Clk_40);

    // table sweeps, back-to-back (each Prf arrives the cycle after DONE)
    for (int i = 0; i < NTBL; i++) begin
      fill_bg(100, 100);
      data[tbl[i].gate] = tbl[i].val;
      drive_sweep(NG, tbl[i].t, 1'b0, tbl[i].flag ? tbl[i].gate : -1);
    end

    // independent counts across back-to-back sweeps: 3 spikes then 2
    fill_bg(95, 105);
    data[150] = 300; data[400] = 300; data[600] = 300;
    drive_sweep(NG, 16'd32, 1'b1, -1);
    fill_bg(95, 105);
    data[20] = 300; data[700] = 300;
    drive_sweep(NG, 16'd32, 1'b1, -1);

    // mid-sweep restart at gate 400: gate 395's flag must never appear
    fill_bg(100, 100);
    data[200] = 250; data[395] = 250;
    drive_sweep(400, 16'd32, 1'b1, -1);
    fill_bg(100, 100);
    data[50] = 250;
    drive_sweep(NG, 16'd32, 1'b1, -1);

    // async reset mid-RUN, between edges
    fill_bg(100, 100);
    data[100] = 250; data[295] = 250;
    drive_sweep(300, 16'd32, 1'b1, -1);
    #2;
    Rst = 1'b1;
    #1;
    check("arst_target_flag", Target_flag, 0);
    check("arst_target_gate", Target_gate, 0);
    check("arst_prf_out", Prf_out, 0);
    check("arst_det_count", Det_count, 0);
    check("arst_state", dbg_state, ST_IDLE);
    prev_cnt = 0;
    @(posedge Clk_40); @(posedge Clk_40); #1;
    Rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk_40); #1;
      Data_in = (i % 7 == 3) ? 32'd5000 : 32'd100;
    end
    check("idle_state_after_reset", dbg_state, ST_IDLE);
    fill_bg(100, 100);
    data[50] = 250;
    drive_sweep(NG, 16'd32, 1'b1, -1);

    repeat (30) @(posedge Clk_40);
    #1;
    check("final_det_count", Det_count, prev_cnt);
    check("final_state", dbg_state, ST_IDLE);
    check("missing_flags", exp_q.size(), 0);
    check("missing_prf_out", prf_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ca_cfar_detector.md
# ca_cfar_detector

Cell-averaging CFAR detector for the receive chain's output end. It consumes the per-range-gate magnitude stream that follows each PRF strobe and compares every cell under test (CUT) against a scaled average of its leading and lagging reference cells. It emits a per-gate detection flag, the gate index, a realigned PRF strobe and a per-sweep detection count. It sits after the pulse-compression magnitude stage (`sqrt2` output) in the `Clk_40` domain.

## Interface
Parameters:
- DATA_W, 32: magnitude sample width, unsigned.
- REF, 8: reference cells per side. 2·REF must be a power of two; LOG2_2R = log2(2·REF).
- GUARD, 1: guard cells per side.
- GATE_W, 10: gate index width.
- NUM_GATES, 800: range gates per sweep, must be ≤ 2^GATE_W.

Ports:
- Clk_40 in 1: the only clock. All logic is on its rising edge.
- Rst in 1: reset, asynchronous and active-high.
- Prf_in in 1: single-cycle sweep-start strobe.
- Data_in in DATA_W: magnitude sample, one per cycle.
- T in 16: threshold factor, unsigned Q12.4 (32 = 2.0), sampled on Prf_in.
- Target_flag out 1: one-cycle detection pulse.
- Target_gate out GATE_W: CUT index. Valid when Target_flag=1, otherwise holds its last value.
- Prf_out out 1: Prf_in delayed by L = REF+GUARD+2 cycles.
- Det_count out GATE_W: detections in the previous sweep. Updated at sweep end.

## Operation
- **Gate mapping:** gate 0 is the Data_in presented on the cycle after Prf_in. Gates 0..NUM_GATES-1 are accepted, one per cycle. Samples outside a sweep are ignored.
- **FSM states:**
  - IDLE: wait for Prf_in.
  - FILL: gate counter g < 2·(REF+GUARD); window loading, no evaluation.
  - RUN: one CUT evaluated per accepted sample.
  - DONE: one cycle; latch the detection counter into Det_count; then go to IDLE.
- **Window:** shift register of W = 2·REF+2·GUARD+1 samples. The CUT is the middle element.
- **Reference sums:** running sums S_lead and S_lag, each DATA_W+LOG2_2R-1 bits. On each shift, add the cell that enters each reference region and subtract the cell that leaves it. No full recompute.
- **Evaluated CUT range:** gates REF+GUARD .. NUM_GATES-1-REF-GUARD only. Edge gates never flag.
- **Detection rule:** (CUT << (LOG2_2R+4)) > T·(S_lead+S_lag). Full-width unsigned compare, no truncation. Equality does not flag.
- **T handling:** T is registered on Prf_in and held for the whole sweep.
- **Prf_in in any state, including mid-sweep:**
  - Restart the sweep and clear the window, sums and gate counter.
  - Latch the current detection count into Det_count.
  - Suppress every not-yet-emitted flag from the old sweep; the valid shift bits are cleared.
- **Detection counter:** saturates at 2^GATE_W-1.
- **Reset values:**
  - Target_flag=0, Target_gate=0, Prf_out=0, Det_count=0.
  - FSM in IDLE; window, sums, counters and latched T all zero.

## Timing
- Sample for gate k is accepted at cycle t_k = t_Prf+1+k.
- The flag for CUT g appears at t_g + L, where L = REF+GUARD+2:
  - 1 cycle for shift and sum update;
  - 1 cycle for the registered multiply/compare.
- Prf_out therefore precedes the flag for gate g by exactly g+1 cycles.
- The last flag of a sweep is for gate NUM_GATES-1-REF-GUARD.
- DONE is the cycle after gate NUM_GATES-1 is accepted. Det_count is updated on the following edge.
- Back-to-back sweeps are allowed: Prf_in may arrive the cycle after DONE.

## Structure
- **Shared package:** FSM state enum, the derived constants W, L and LOG2_2R, and the Q12.4 fraction width (4).
- **Sub-module `cfar_window`:** shift register plus running sums. Outputs the CUT, S_lead+S_lag and a CUT-valid bit. The top level holds the FSM, compare stage, counters and Prf delay line.

## Test plan
All scenarios use default parameters and T=32.
1. **Detection:** background 100 on all gates, spike 250 at gate 100 → exactly one flag, Target_gate=100, at t_100+11; Det_count=1 after the sweep.
2. **Threshold boundary:** spike 200 → no flag (51200 is not > 51200). Spike 199 → no flag. Spike 201 → flag.
3. **Edge gates:** spikes at gates 5 and 795 (outside 9..790) → no flags, Det_count=0.
4. **Mid-sweep restart:** Prf_in at gate 400 with spike at gate 395 → no flag for 395. Det_count latches the count up to that point. The new sweep detects a spike at gate 50.
5. **Async reset mid-RUN:** assert Rst between edges → all outputs 0 immediately; no flags until the next Prf_in plus a full window fill.
6. **Prf alignment and back-to-back sweeps:** Prf_out appears 11 cycles after Prf_in. Two sweeps with a 1-cycle gap give independent correct counts (3 spikes, then 2 spikes → Det_count 3, then 2).
